// File: rtl/branch_predict_unit.sv
// Branch predictor: direct-mapped BTB with 2-bit counters, decode-stage resolve and redirect.
// Optional macro BPU_BTB_EN builds the BTB; without it nothing is predicted and every taken branch redirects.
module branch_predict_unit #(
    parameter int XLEN      = 32,
    parameter int BTB_DEPTH = 16,
    parameter int IDX       = $clog2(BTB_DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic [XLEN-1:0] pc_f,
    output logic            pred_taken_f,
    output logic [XLEN-1:0] pred_target_f,
    input  logic [XLEN-1:0] pc_d,
    input  logic [2:0]      br_op_d,
    input  logic [XLEN-1:0] imm_d,
    input  logic [25:0]     jidx_d,
    input  logic [XLEN-1:0] rs_d,
    input  logic [XLEN-1:0] rt_d,
    input  logic [1:0]      fwd_s,
    input  logic [1:0]      fwd_t,
    input  logic [XLEN-1:0] alu_e,
    input  logic [XLEN-1:0] alu_m,
    input  logic [XLEN-1:0] wb_w,
    output logic            redirect_d,
    output logic [XLEN-1:0] redirect_pc_d,
    output logic [15:0]     mispred_cnt
);
    logic [XLEN-1:0] s_op, t_op, pc_plus4, br_tgt, j_tgt, act_tgt;
    logic            act_taken, upd_en, alias_hit, redirect;
    logic            pred_taken_q, pred_taken_d;
    logic [XLEN-1:0] pred_target_q, pred_target_d;
    logic [15:0]     mispred_q, mispred_d;
    logic            unused_bits;

    always_comb begin
        s_op = rs_d;
        t_op = rt_d;
        case (fwd_s)
            2'd1:    s_op = alu_e;
            2'd2:    s_op = alu_m;
            2'd3:    s_op = wb_w;
            default: s_op = rs_d;
        endcase
        case (fwd_t)
            2'd1:    t_op = alu_e;
            2'd2:    t_op = alu_m;
            2'd3:    t_op = wb_w;
            default: t_op = rt_d;
        endcase
    end

    assign pc_plus4 = pc_d + XLEN'(4);
    assign br_tgt   = pc_plus4 + {imm_d[XLEN-3:0], 2'b00};
    assign j_tgt    = {pc_plus4[XLEN-1:28], jidx_d, 2'b00};

    always_comb begin
        act_taken = 1'b0;
        act_tgt   = br_tgt;
        case (br_op_d)
            3'd1: act_taken = (s_op == t_op);
            3'd2: act_taken = (s_op != t_op);
            3'd3: act_taken = ~s_op[XLEN-1] & (|s_op);
            3'd4: act_taken = s_op[XLEN-1];
            3'd5: act_taken = ~s_op[XLEN-1];
            3'd6: begin
                act_taken = 1'b1;
                act_tgt   = j_tgt;
            end
            3'd7: begin
                act_taken = 1'b1;
                act_tgt   = s_op;
            end
            default: act_taken = 1'b0;
        endcase
    end

    // A registered taken prediction on a non-branch means the BTB aliased; fall through to pc+4.
    assign upd_en    = (br_op_d != 3'd0) & ~stall_d & ~flush_d;
    assign alias_hit = (br_op_d == 3'd0) & pred_taken_q & ~stall_d & ~flush_d;
    assign redirect  = (upd_en & ((pred_taken_q != act_taken) |
                                  (pred_taken_q & act_taken & (pred_target_q != act_tgt)))) | alias_hit;

    assign redirect_d    = redirect;
    assign redirect_pc_d = redirect ? (act_taken ? act_tgt : pc_plus4) : '0;
    assign mispred_cnt   = mispred_q;

    always_comb begin
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        if (flush_d) begin
            pred_taken_d  = 1'b0;
            pred_target_d = '0;
        end else if (!stall_d) begin
            pred_taken_d  = pred_taken_f;
            pred_target_d = pred_target_f;
        end
    end

    assign mispred_d = (redirect && (mispred_q != 16'hFFFF)) ? mispred_q + 16'd1 : mispred_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            mispred_q     <= '0;
        end else begin
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            mispred_q     <= mispred_d;
        end
    end

`ifdef BPU_BTB_EN
    localparam int TAGW = XLEN - IDX - 2;

    logic [BTB_DEPTH-1:0] valid_q;
    logic [TAGW-1:0]      tag_q [BTB_DEPTH];
    logic [XLEN-1:0]      tgt_q [BTB_DEPTH];
    logic [1:0]           ctr_q [BTB_DEPTH];
    logic [IDX-1:0]       f_idx, d_idx;
    logic                 f_hit, d_hit;

    assign f_idx = pc_f[IDX+1:2];
    assign d_idx = pc_d[IDX+1:2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == pc_f[XLEN-1:IDX+2]);
    assign d_hit = valid_q[d_idx] && (tag_q[d_idx] == pc_d[XLEN-1:IDX+2]);

    assign pred_taken_f  = f_hit & ctr_q[f_idx][1];
    assign pred_target_f = f_hit ? tgt_q[f_idx] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= '0;
            end
        end else if (alias_hit) begin
            valid_q[d_idx] <= 1'b0;
        end else if (upd_en) begin
            if (act_taken) begin
                valid_q[d_idx] <= 1'b1;
                tag_q[d_idx]   <= pc_d[XLEN-1:IDX+2];
                tgt_q[d_idx]   <= act_tgt;
                if (d_hit)
                    ctr_q[d_idx] <= (ctr_q[d_idx] == 2'b11) ? 2'b11 : ctr_q[d_idx] + 2'd1;
                else
                    ctr_q[d_idx] <= 2'b10;
            end else if (d_hit && (ctr_q[d_idx] != 2'b00)) begin
                ctr_q[d_idx] <= ctr_q[d_idx] - 2'd1;
            end
        end
    end
`else
    assign pred_taken_f  = 1'b0;
    assign pred_target_f = '0;
`endif

    assign unused_bits = ^{pc_f, imm_d[XLEN-1:XLEN-2], 1'(IDX)};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios plus randomized traffic against a BTB model.
module tb_branch_predict_unit;
    localparam int DEPTH = 16;
`ifdef BPU_BTB_EN
    localparam bit BTB_ON = 1'b1;
`else
    localparam bit BTB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, stall_d, flush_d;
    logic [31:0] pc_f, pc_d, imm_d, rs_d, rt_d, alu_e, alu_m, wb_w;
    logic [2:0]  br_op_d;
    logic [25:0] jidx_d;
    logic [1:0]  fwd_s, fwd_t;
    logic        pred_taken_f, redirect_d;
    logic [31:0] pred_target_f, redirect_pc_d;
    logic [15:0] mispred_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: table kept as full PCs, counters as plain integers.
    bit          m_valid [DEPTH];
    logic [31:0] m_pc    [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    int          m_ctr   [DEPTH];
    bit          m_ptaken;
    logic [31:0] m_ptgt;
    int          m_cnt;

    bit          e_ftaken, e_redir, a_taken, e_dhit;
    logic [31:0] e_ftgt, e_rpc, a_tgt;

    branch_predict_unit dut (
        .clk(clk), .rst_n(rst_n), .stall_d(stall_d), .flush_d(flush_d),
        .pc_f(pc_f), .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
        .pc_d(pc_d), .br_op_d(br_op_d), .imm_d(imm_d), .jidx_d(jidx_d),
        .rs_d(rs_d), .rt_d(rt_d), .fwd_s(fwd_s), .fwd_t(fwd_t),
        .alu_e(alu_e), .alu_m(alu_m), .wb_w(wb_w),
        .redirect_d(redirect_d), .redirect_pc_d(redirect_pc_d), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r);
        case (sel)
            2'd1:    return alu_e;
            2'd2:    return alu_m;
            2'd3:    return wb_w;
            default: return r;
        endcase
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        int idx = int'((pc / 4) % DEPTH);
        return BTB_ON && m_valid[idx] && ((m_pc[idx] / 64) == (pc / 64));
    endfunction

    task automatic model_eval();
        logic [31:0] s, t, p4;
        int fi;
        bit live;
        fi       = int'((pc_f / 4) % DEPTH);
        e_ftaken = model_hit(pc_f) && (m_ctr[fi] >= 2);
        e_ftgt   = model_hit(pc_f) ? m_tgt[fi] : 32'd0;
        e_dhit   = model_hit(pc_d);
        s  = pick(fwd_s, rs_d);
        t  = pick(fwd_t, rt_d);
        p4 = pc_d + 32'd4;
        case (br_op_d)
            3'd1:    a_taken = (s == t);
            3'd2:    a_taken = (s != t);
            3'd3:    a_taken = ($signed(s) > 0);
            3'd4:    a_taken = ($signed(s) < 0);
            3'd5:    a_taken = ($signed(s) >= 0);
            3'd6:    a_taken = 1'b1;
            3'd7:    a_taken = 1'b1;
            default: a_taken = 1'b0;
        endcase
        if (br_op_d == 3'd6)      a_tgt = {p4[31:28], jidx_d, 2'b00};
        else if (br_op_d == 3'd7) a_tgt = s;
        else                      a_tgt = p4 + imm_d * 4;
        live    = !stall_d && !flush_d;
        e_redir = live && ((br_op_d != 0 && (m_ptaken != a_taken || (m_ptaken && a_taken && m_ptgt != a_tgt)))
                           || (br_op_d == 0 && m_ptaken));
        e_rpc   = e_redir ? (a_taken ? a_tgt : p4) : 32'd0;
    endtask

    task automatic model_commit();
        int di;
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_valid[i] = 0; m_pc[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
            end
            m_ptaken = 0; m_ptgt = 0; m_cnt = 0;
            return;
        end
        if (e_redir && m_cnt < 65535) m_cnt++;
        di = int'((pc_d / 4) % DEPTH);
        if (!stall_d && !flush_d) begin
            if (br_op_d == 0 && m_ptaken) m_valid[di] = 0;
            else if (br_op_d != 0 && a_taken) begin
                m_ctr[di]   = e_dhit ? ((m_ctr[di] < 3) ? m_ctr[di] + 1 : 3) : 2;
                m_valid[di] = 1; m_pc[di] = pc_d; m_tgt[di] = a_tgt;
            end else if (br_op_d != 0 && e_dhit && m_ctr[di] > 0) m_ctr[di]--;
        end
        if (flush_d) begin
            m_ptaken = 0; m_ptgt = 0;
        end else if (!stall_d) begin
            m_ptaken = e_ftaken; m_ptgt = e_ftgt;
        end
    endtask

    task automatic look(input bit chk);
        @(negedge clk);
        model_eval();
        if (chk) begin
            check("pred_taken_f", pred_taken_f, e_ftaken);
            check("pred_target_f", pred_target_f, e_ftgt);
            check("redirect_d", redirect_d, e_redir);
            check("redirect_pc_d", redirect_pc_d, e_rpc);
            check("mispred_cnt", mispred_cnt, m_cnt);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle();
        rst_n = 1; stall_d = 0; flush_d = 0; pc_f = 32'h800; pc_d = 32'h0;
        br_op_d = 0; imm_d = 0; jidx_d = 0; rs_d = 0; rt_d = 0;
        fwd_s = 0; fwd_t = 0; alu_e = 0; alu_m = 0; wb_w = 0;
    endtask

    task automatic set_br(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] s,
                          input logic [31:0] t, input logic [31:0] imm);
        br_op_d = op; pc_d = pc; rs_d = s; rt_d = t; imm_d = imm;
    endtask

    function automatic logic [31:0] rval();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'd5;
            2:       return 32'hFFFF_FFFB;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rpc();
        case ($urandom_range(0, 4))
            0:       return 32'h40;
            1:       return 32'h80;
            2:       return 32'hC0;
            3:       return 32'h440;
            default: return $urandom & 32'h0FFF_FFFC;
        endcase
    endfunction

    initial begin
        int tmp;
        idle();
        rst_n = 0;
        look(0); tick();
        look(0); tick();
        rst_n = 1;
        look(1);
        check("rst_pred_taken", pred_taken_f, 0);
        check("rst_mispred", mispred_cnt, 0);
        tick();

        // beq at 0x40, S==T, imm 3: taken to 0x50, predicted not-taken
        set_br(3'd1, 32'h40, 32'd5, 32'd5, 32'd3);
        look(1);
        check("beq_redirect", redirect_d, 1);
        check("beq_redirect_pc", redirect_pc_d, 32'h50);
        tick();
        idle();
        look(1);
        check("beq_mispred_cnt", mispred_cnt, 1);
        tick();

        // Re-fetch 0x40, then decode the same beq
        pc_f = 32'h40;
        look(1);
        check("train_pred_taken", pred_taken_f, BTB_ON);
        check("train_pred_target", pred_target_f, BTB_ON ? 32'h50 : 32'h0);
        tick();
        idle();
        set_br(3'd1, 32'h40, 32'd5, 32'd5, 32'd3);
        look(1);
        check("train_redirect", redirect_d, !BTB_ON);
        tick();

        // bne not-taken twice on the trained entry; fetch overlaps each update
        idle(); pc_f = 32'h40;
        look(1); tick();
        for (int k = 0; k < 2; k++) begin
            idle(); pc_f = 32'h40;
            set_br(3'd2, 32'h40, 32'd5, 32'd5, 32'd3);
            look(1);
            check("bne_redirect", redirect_d, BTB_ON);
            check("bne_redirect_pc", redirect_pc_d, BTB_ON ? 32'h44 : 32'h0);
            tick();
        end
        idle(); pc_f = 32'h40; flush_d = 1;
        look(1);
        check("bne_weak_pred", pred_taken_f, 0);
        tick();

        // jr through alu_m forward, first stalled then released
        idle();
        br_op_d = 3'd7; pc_d = 32'h80; fwd_s = 2'd2; alu_m = 32'h1000; rs_d = 0; stall_d = 1;
        look(1);
        check("jr_stall_redirect", redirect_d, 0);
        check("jr_stall_pc", redirect_pc_d, 0);
        tick();
        stall_d = 0;
        look(1);
        check("jr_redirect_pc", redirect_pc_d, 32'h1000);
        tick();

        // Aliased hit on a non-branch: fall through and invalidate
        idle(); pc_f = 32'h80;
        look(1); tick();
        idle(); pc_d = 32'h80;
        look(1);
        check("alias_redirect", redirect_d, BTB_ON);
        check("alias_redirect_pc", redirect_pc_d, BTB_ON ? 32'h84 : 32'h0);
        tick();
        idle(); pc_f = 32'h80;
        look(1);
        check("alias_invalidated", pred_taken_f, 0);
        tick();

        // Randomized traffic; decode follows the previous fetch PC so predictions matter
        for (int n = 0; n < 600; n++) begin
            logic [31:0] prev_f;
            prev_f  = pc_f;
            pc_f    = rpc();
            pc_d    = ($urandom_range(0, 3) != 0) ? prev_f : rpc();
            br_op_d = 3'($urandom_range(0, 7));
            rs_d    = rval(); rt_d = rval();
            alu_e   = rval(); alu_m = rval(); wb_w = rval();
            fwd_s   = 2'($urandom_range(0, 3)); fwd_t = 2'($urandom_range(0, 3));
            tmp     = $urandom_range(0, 15);
            imm_d   = tmp - 8;
            jidx_d  = 26'($urandom);
            stall_d = ($urandom_range(0, 5) == 0);
            flush_d = ($urandom_range(0, 7) == 0);
            look(1);
            tick();
        end

        // Saturate the mispredict counter with a stream of unpredicted jr
        idle(); rst_n = 0;
        look(0); tick();
        idle(); pc_f = 32'h800; br_op_d = 3'd7; pc_d = 32'h100; rs_d = 32'h2000;
        for (int n = 0; n < 65540; n++) begin
            look(0); tick();
        end
        look(1);
        check("mispred_saturated", mispred_cnt, 16'hFFFF);
        tick();

        // Reset during a pending update must discard it
        idle(); set_br(3'd1, 32'hC0, 32'd1, 32'd1, 32'd4); pc_f = 32'h100; rst_n = 0;
        look(0); tick();
        idle(); pc_f = 32'h100;
        look(1);
        check("post_rst_pred", pred_taken_f, 0);
        check("post_rst_target", pred_target_f, 0);
        check("post_rst_redirect", redirect_d, 0);
        check("post_rst_cnt", mispred_cnt, 0);
        tick();
        pc_f = 32'hC0;
        look(1);
        check("post_rst_no_commit", pred_target_f, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- XLEN, 32, datapath width.
- BTB_DEPTH, 16, number of BTB entries, power of two, at least 2.
- IDX = log2(BTB_DEPTH).
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, reset, synchronous, active-low.
- stall_d, in, 1, decode stage held.
- flush_d, in, 1, decode instruction squashed.
- pc_f, in, XLEN, fetch PC.
- pred_taken_f, out, 1, fetch redirect predicted.
- pred_target_f, out, XLEN, predicted fetch target.
- pc_d, in, XLEN, decode PC.
- br_op_d, in, 3, 0 none, 1 beq, 2 bne, 3 bgtz, 4 bltz, 5 bgez, 6 j, 7 jr.
- imm_d, in, XLEN, sign-extended immediate.
- jidx_d, in, 26, j instruction index.
- rs_d, in, XLEN, register-file value of rs.
- rt_d, in, XLEN, register-file value of rt.
- fwd_s, in, 2, forward select for rs: 0 reg, 1 alu_e, 2 alu_m, 3 wb_w.
- fwd_t, in, 2, forward select for rt: 0 reg, 1 alu_e, 2 alu_m, 3 wb_w.
- alu_e, in, XLEN, forwarding source.
- alu_m, in, XLEN, forwarding source.
- wb_w, in, XLEN, forwarding source.
- redirect_d, out, 1, mispredict, refetch.
- redirect_pc_d, out, XLEN, correct next PC.
- mispred_cnt, out, 16, saturating mispredict counter.

Function
REQ-003 BTB entry SHALL hold valid, tag pc[XLEN-1:IDX+2], target XLEN, 2-bit counter; index = pc[IDX+1:2].
REQ-004 Fetch lookup SHALL be combinational: hit = valid & tag match; pred_taken_f = hit & ctr[1]; pred_target_f = entry target, or 0 when no hit.
REQ-005 On a clock edge with ~stall_d, fetch prediction (taken, target) SHALL register into decode; with stall_d it SHALL hold; with flush_d it SHALL clear to not-taken.
REQ-006 Operands SHALL be muxed by fwd_s/fwd_t before comparison.
REQ-007 Actual taken SHALL be resolved as follows:
- beq: S==T.
- bne: S!=T.
- bgtz: signed S>0.
- bltz: S[XLEN-1].
- bgez: ~S[XLEN-1].
- j, jr: always taken.
- op 0: never taken.
REQ-008 Actual target SHALL be computed as follows:
- branch: pc_d+4+(imm_d<<2), modulo 2^XLEN.
- j: {(pc_d+4)[XLEN-1:28], jidx_d, 2'b00}.
- jr: S.
REQ-009 redirect_d SHALL be combinational, asserted when op!=0 & ~flush_d & ~stall_d and either condition holds:
- predicted direction != actual direction;
- both taken and targets differ.
REQ-010 redirect_pc_d SHALL be the actual target if taken, else pc_d+4; it SHALL be 0 when redirect_d=0.
REQ-011 Op 0 with a registered taken prediction (aliased BTB hit) SHALL redirect to pc_d+4 and invalidate that entry.
REQ-012 Update SHALL occur on a clock edge when op!=0 & ~stall_d & ~flush_d:
- hit, taken: counter saturating increment, target overwritten.
- hit, not taken: counter saturating decrement.
- miss, taken: allocate with counter 2'b10.
- miss, not taken: no change.
REQ-013 Simultaneous lookup and update of the same index SHALL return pre-update contents (read-before-write).
REQ-014 mispred_cnt SHALL increment once per redirect_d cycle, saturating at 16'hFFFF.
REQ-015 Latency:
- prediction to fetch: 0 cycles.
- redirect: 0 cycles in decode.
- table update: visible to lookups 1 cycle later.

Reset
REQ-016 On a clock edge with rst_n=0, all valid bits, counters, targets, the decode prediction register and mispred_cnt SHALL clear to 0; outputs SHALL be 0 during the following cycle.
REQ-017 Reset asserted mid-stall or mid-update SHALL override all other inputs; no update SHALL commit on that edge.

Configuration
REQ-018 Macro BPU_BTB_EN defined: BTB behaviour per REQ-003..REQ-013.
REQ-019 Macro BPU_BTB_EN undefined:
- no BTB storage;
- pred_taken_f=0 and pred_target_f=0 permanently;
- every taken branch or jump SHALL redirect;
- mispred_cnt SHALL remain functional.

Verification
REQ-020 After reset, beq at pc_d=0x40 with S=T=5, imm=3 -> redirect_d=1, redirect_pc_d=0x50, mispred_cnt=1.
REQ-021 Same beq repeated after update, pc_f=0x40 -> pred_taken_f=1, pred_target_f=0x50; on decode no redirect, counter 2'b11.
REQ-022 bne S=T at trained entry -> redirect_d=1, redirect_pc_d=0x44, counter decrements to 2'b10; second not-taken gives 2'b01 and pred_taken_f=0.
REQ-023 jr with fwd_s=2, alu_m=0x1000, rs_d=0 -> redirect_pc_d=0x1000; stall_d=1 the same cycle -> redirect_d=0 and no BTB change.
REQ-024 Force 65536 mispredicts -> mispred_cnt holds at 0xFFFF; rst_n=0 for one edge -> all outputs 0 and pc_f lookups miss.
REQ-025 BPU_BTB_EN undefined, repeat REQ-021 -> pred_taken_f=0 and redirect_d=1 every time.
